// File: rtl/xike_pkg.sv
// Shared definitions for the xike spike detector.
//   TS_W / CH_W   : timestamp and channel field widths of a spike event
//   EVT_*         : bit layout of the 32-bit event word {ts, pol, ch}
//   to_signed()   : offset-binary sample to two's complement
package xike_pkg;

   localparam int unsigned TS_W = 23;
   localparam int unsigned CH_W = 8;

   localparam int unsigned EVT_CH_LSB  = 0;
   localparam int unsigned EVT_POL_BIT = CH_W;
   localparam int unsigned EVT_TS_LSB  = CH_W + 1;
   localparam int unsigned EVT_W       = TS_W + 1 + CH_W;

   // 16'h8000 is 0 V; flipping the MSB yields the signed value.
   function automatic logic signed [15:0] to_signed(input logic [15:0] d);
      return {~d[15], d[14:0]};
   endfunction

endpackage

// File: rtl/xike_evt_fifo.sv
// Synchronous event FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and data
//   pop_i         : read request (ignored when empty)
//   data_o        : head entry (meaningful only when empty_o = 0)
//   empty_o       : no entries stored
//   drop_o        : push refused because full with no simultaneous pop
module xike_evt_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW  = AddrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             full, do_pop, do_push;

   assign full    = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   // A pop frees the head slot this cycle, so a push into a full FIFO still fits.
   assign do_push = push_i & (~full | do_pop);
   assign drop_o  = push_i & ~do_push;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/xike_spike_detector.sv
// Per-channel threshold-crossing spike detector with refractory lockout.
//   spi_clk, reset_n          : clock, asynchronous active-low reset
//   FIFO_DATA_TO_XIKE(_WEN)   : offset-binary sample stream, one sample per WEN cycle
//   sof                       : marks channel 0 of a frame
//   detect_en                 : detection enable
//   thr_we/thr_addr/thr_data  : per-channel threshold write port
//   ovf_clr                   : clears the sticky evt_overflow / frame_err flags
//   spk_valid/ready/data      : event stream {ts[22:0], pol, ch[7:0]}
//   evt_overflow, frame_err   : sticky error flags
// Optional feature: define XIKE_DUAL_POLARITY_EN to also detect positive crossings.
// Pipeline: stage 1 captures the sample, stage 2 reads channel state (registered)
// then evaluates and writes back; the event reaches spk_valid three edges after WEN.
module xike_spike_detector
   import xike_pkg::*;
#(
   parameter int unsigned NUM_CH      = 32,
   parameter int unsigned REFRACT     = 30,
   parameter logic [15:0] THR_DEFAULT = 16'h0200,
   parameter int unsigned EVT_DEPTH   = 16
) (
   input  logic        spi_clk,
   input  logic        reset_n,
   input  logic [15:0] FIFO_DATA_TO_XIKE,
   input  logic        FIFO_DATA_TO_XIKE_WEN,
   input  logic        sof,
   input  logic        detect_en,
   input  logic        thr_we,
   input  logic [7:0]  thr_addr,
   input  logic [15:0] thr_data,
   input  logic        ovf_clr,
   output logic        spk_valid,
   input  logic        spk_ready,
   output logic [31:0] spk_data,
   output logic        evt_overflow,
   output logic        frame_err
);

   localparam int unsigned     IdxW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_CH - 1);
   localparam logic [7:0]      RefrInit = 8'(REFRACT);

   // Channel index and frame timestamp
   logic [IdxW-1:0] idx_q, idx_d, smp_idx;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            sof_err;

   always_comb begin
      smp_idx = sof ? '0 : idx_q;
      sof_err = FIFO_DATA_TO_XIKE_WEN & sof & (idx_q != '0);
      idx_d   = idx_q;
      ts_d    = ts_q;
      if (FIFO_DATA_TO_XIKE_WEN) begin
         if (smp_idx == LastIdx) begin
            idx_d = '0;
            ts_d  = ts_q + 1'b1;
         end else begin
            idx_d = smp_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q <= '0;
         ts_q  <= '0;
      end else begin
         idx_q <= idx_d;
         ts_q  <= ts_d;
      end
   end

   // Per-channel state
   logic [15:0]       thr_q [NUM_CH];
   logic [NUM_CH-1:0] prev_below_q;
   logic [7:0]        refr_q [NUM_CH];
   logic              thr_ok;

   assign thr_ok = thr_we & (32'(thr_addr) < NUM_CH);

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) thr_q[i] <= THR_DEFAULT;
      end else if (thr_ok) begin
         thr_q[thr_addr[IdxW-1:0]] <= thr_data;
      end
   end

   // Stage 1: sample capture
   logic                s1_vld_q;
   logic signed [15:0]  s1_smp_q;
   logic [IdxW-1:0]     s1_idx_q;
   logic [TS_W-1:0]     s1_ts_q;

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld_q <= 1'b0;
         s1_smp_q <= '0;
         s1_idx_q <= '0;
         s1_ts_q  <= '0;
      end else begin
         s1_vld_q <= FIFO_DATA_TO_XIKE_WEN;
         if (FIFO_DATA_TO_XIKE_WEN) begin
            s1_smp_q <= to_signed(FIFO_DATA_TO_XIKE);
            s1_idx_q <= smp_idx;
            s1_ts_q  <= ts_q;
         end
      end
   end

   // Stage 2a: state read
   logic                rd_vld_q;
   logic signed [15:0]  rd_smp_q;
   logic [IdxW-1:0]     rd_idx_q;
   logic [TS_W-1:0]     rd_ts_q;
   logic [15:0]         rd_thr_q;
   logic                rd_prev_below_q;
   logic [7:0]          rd_refr_q;
   logic                fwd;

   // Stage 2b: evaluation
   logic signed [16:0]  s_ext, thr_ext;
   logic                below, neg_x, pos_x, spike, pol;
   logic [7:0]          refr_nxt;

   // The sample under evaluation writes back on the same edge the next sample reads;
   // forward its result when both address the same channel (NUM_CH = 1, early sof).
   assign fwd = rd_vld_q & (rd_idx_q == s1_idx_q);

`ifdef XIKE_DUAL_POLARITY_EN
   logic [NUM_CH-1:0] prev_above_q;
   logic              rd_prev_above_q;
   logic              above;

   assign above = s_ext > thr_ext;
   assign pos_x = above & ~rd_prev_above_q;

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_above_q    <= '0;
         rd_prev_above_q <= 1'b0;
      end else begin
         if (s1_vld_q) rd_prev_above_q <= fwd ? above : prev_above_q[s1_idx_q];
         if (rd_vld_q) prev_above_q[rd_idx_q] <= above;
      end
   end
`else
   assign pos_x = 1'b0;
`endif

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_vld_q        <= 1'b0;
         rd_smp_q        <= '0;
         rd_idx_q        <= '0;
         rd_ts_q         <= '0;
         rd_thr_q        <= '0;
         rd_prev_below_q <= 1'b0;
         rd_refr_q       <= '0;
      end else begin
         rd_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            rd_smp_q        <= s1_smp_q;
            rd_idx_q        <= s1_idx_q;
            rd_ts_q         <= s1_ts_q;
            rd_thr_q        <= thr_q[s1_idx_q];
            rd_prev_below_q <= fwd ? below : prev_below_q[s1_idx_q];
            rd_refr_q       <= fwd ? refr_nxt : refr_q[s1_idx_q];
         end
      end
   end

   assign s_ext   = {rd_smp_q[15], rd_smp_q};
   assign thr_ext = {1'b0, rd_thr_q};
   assign below   = s_ext < -thr_ext;
   assign neg_x   = below & ~rd_prev_below_q;
   assign spike   = detect_en & (neg_x | pos_x) & (rd_refr_q == '0);
   // Negative crossing wins when both occur on one sample.
   assign pol     = ~neg_x & pos_x;

   always_comb begin
      refr_nxt = rd_refr_q;
      if (!detect_en)               refr_nxt = '0;
      else if (spike)               refr_nxt = RefrInit;
      else if (rd_refr_q != '0)     refr_nxt = rd_refr_q - 1'b1;
   end

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_below_q <= '0;
         for (int i = 0; i < NUM_CH; i++) refr_q[i] <= '0;
      end else if (rd_vld_q) begin
         prev_below_q[rd_idx_q] <= below;
         refr_q[rd_idx_q]       <= refr_nxt;
      end
   end

   // Event register feeding the FIFO
   logic             evt_vld_q;
   logic [EVT_W-1:0] evt_q, evt_d;

   always_comb begin
      evt_d                           = '0;
      evt_d[EVT_TS_LSB +: TS_W]       = rd_ts_q;
      evt_d[EVT_POL_BIT]              = pol;
      evt_d[EVT_CH_LSB +: CH_W]       = CH_W'(rd_idx_q);
   end

   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         evt_vld_q <= 1'b0;
         evt_q     <= '0;
      end else begin
         evt_vld_q <= rd_vld_q & spike;
         if (rd_vld_q & spike) evt_q <= evt_d;
      end
   end

   logic [EVT_W-1:0] fifo_data;
   logic             fifo_empty, fifo_drop, pop;

   assign spk_valid = ~fifo_empty;
   assign pop       = spk_valid & spk_ready;
   assign spk_data  = spk_valid ? fifo_data : '0;

   xike_evt_fifo #(
      .Width (EVT_W),
      .Depth (EVT_DEPTH)
   ) u_evt_fifo (
      .clk_i   (spi_clk),
      .rst_ni  (reset_n),
      .push_i  (evt_vld_q),
      .data_i  (evt_q),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop)
   );

   // Sticky flags: a new error in the clear cycle keeps the flag set.
   always_ff @(posedge spi_clk or negedge reset_n) begin
      if (!reset_n) begin
         evt_overflow <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         if (fifo_drop)    evt_overflow <= 1'b1;
         else if (ovf_clr) evt_overflow <= 1'b0;
         if (sof_err)      frame_err <= 1'b1;
         else if (ovf_clr) frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xike_spike_detector.sv
// Directed self-checking bench for xike_spike_detector (default parameters).
module tb_xike_spike_detector;

   logic        spi_clk = 1'b0;
   logic        reset_n;
   logic [15:0] data;
   logic        wen, sof, detect_en, thr_we, ovf_clr, spk_ready;
   logic [7:0]  thr_addr;
   logic [15:0] thr_data;
   logic        spk_valid, evt_overflow, frame_err;
   logic [31:0] spk_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] smp [32];
   logic [31:0] got_q [$];
   logic [31:0] req_q [$];

   always #5 spi_clk = ~spi_clk;

   xike_spike_detector dut (
      .spi_clk               (spi_clk),
      .reset_n               (reset_n),
      .FIFO_DATA_TO_XIKE     (data),
      .FIFO_DATA_TO_XIKE_WEN (wen),
      .sof                   (sof),
      .detect_en             (detect_en),
      .thr_we                (thr_we),
      .thr_addr              (thr_addr),
      .thr_data              (thr_data),
      .ovf_clr               (ovf_clr),
      .spk_valid             (spk_valid),
      .spk_ready             (spk_ready),
      .spk_data              (spk_data),
      .evt_overflow          (evt_overflow),
      .frame_err             (frame_err)
   );

   // Log every accepted event; sampled mid-cycle, inputs change just after posedge.
   always @(negedge spi_clk) begin
      if (reset_n && spk_valid && spk_ready) got_q.push_back(spk_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, req);
      end
   endtask

   function automatic logic [31:0] ev(input int unsigned ts, input logic pol,
                                      input int unsigned ch);
      return {ts[22:0], pol, ch[7:0]};
   endfunction

   task automatic tick();
      @(posedge spi_clk);
      #1;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int c = 0; c < 32; c++) smp[c] = v;
   endtask

   // Back-to-back samples for channels lo..hi, sof on channel 0.
   task automatic feed(input int lo, input int hi);
      for (int c = lo; c <= hi; c++) begin
         data = smp[c];
         wen  = 1'b1;
         sof  = (c == 0);
         tick();
      end
      wen = 1'b0;
      sof = 1'b0;
   endtask

   task automatic cmp_events(input string tag);
      check({tag, " count"}, 32'(got_q.size()), 32'(req_q.size()));
      for (int i = 0; i < req_q.size() && i < got_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), got_q[i], req_q[i]);
      got_q.delete();
      req_q.delete();
   endtask

   initial begin
      reset_n   = 1'b0;
      data      = 16'h8000;
      wen       = 1'b0;
      sof       = 1'b0;
      detect_en = 1'b1;
      thr_we    = 1'b0;
      thr_addr  = '0;
      thr_data  = '0;
      ovf_clr   = 1'b0;
      spk_ready = 1'b1;
      set_all(16'h8000);
      repeat (3) tick();
      check("reset spk_valid", 32'(spk_valid), 32'd0);
      check("reset spk_data", spk_data, 32'd0);
      check("reset evt_overflow", 32'(evt_overflow), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      reset_n = 1'b1;
      tick();

      // Frame 0 (ts 0): quiet
      feed(0, 31);

      // Frame 1 (ts 1): ch3 crosses; event must appear 3 edges after acceptance
      smp[3]    = 16'h7D00;
      spk_ready = 1'b0;
      feed(0, 3);
      check("lat +0 valid", 32'(spk_valid), 32'd0);
      tick();
      check("lat +1 valid", 32'(spk_valid), 32'd0);
      tick();
      check("lat +2 valid", 32'(spk_valid), 32'd0);
      tick();
      check("lat +3 valid", 32'(spk_valid), 32'd1);
      check("lat +3 data", spk_data, ev(1, 1'b0, 3));
      feed(4, 31);
      spk_ready = 1'b1;
      repeat (3) tick();
      req_q.push_back(ev(1, 1'b0, 3));
      cmp_events("ch3 event");

      // Frames 2..34: ch3 stays below (no re-trigger); ch0 refractory sequence
      // relative to its spike at frame 2: crossings at +2 and +30 suppressed,
      // +32 fires again. Frame 3 ch1 = 0x8300 (positive crossing only).
      for (int f = 2; f <= 34; f++) begin
         set_all(16'h8000);
         if (f == 2) smp[3] = 16'h7D00;
         if (f == 3) smp[1] = 16'h8300;
         if (f == 2 || f == 4 || f == 32 || f == 34) smp[0] = 16'h7000;
         feed(0, 31);
      end
      repeat (6) tick();
      req_q.push_back(ev(2, 1'b0, 0));
`ifdef XIKE_DUAL_POLARITY_EN
      req_q.push_back(ev(3, 1'b1, 1));
`endif
      req_q.push_back(ev(34, 1'b0, 0));
      cmp_events("refractory");

      // Frame 35: sof at index 5 -> forced to ch0, next sample is ch1, ts unchanged
      set_all(16'h8000);
      feed(0, 4);
      data = 16'h8000;
      wen  = 1'b1;
      sof  = 1'b1;
      tick();
      check("frame_err set", 32'(frame_err), 32'd1);
      data = 16'h7000;
      sof  = 1'b0;
      tick();
      wen = 1'b0;
      feed(2, 31);
      repeat (6) tick();
      req_q.push_back(ev(35, 1'b0, 1));
      cmp_events("frame sync");
      check("frame_err held", 32'(frame_err), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("frame_err cleared", 32'(frame_err), 32'd0);

      // Frame 36: thr[2] <- 0 mid-frame; thr_addr 40 is out of range (must not alias ch8)
      set_all(16'h8000);
      smp[2] = 16'h7FFF;
      smp[8] = 16'h7FFF;
      feed(0, 1);
      thr_we   = 1'b1;
      thr_addr = 8'd2;
      thr_data = 16'h0000;
      tick();
      thr_addr = 8'd40;
      tick();
      thr_we = 1'b0;
      feed(2, 31);
      repeat (6) tick();
      req_q.push_back(ev(36, 1'b0, 2));
      cmp_events("threshold");
      check("frame_err quiet", 32'(frame_err), 32'd0);

      // Frame 37: 17 spikes (ch10..26) with consumer stalled
      set_all(16'h8000);
      for (int c = 10; c <= 26; c++) smp[c] = 16'h7000;
      spk_ready = 1'b0;
      feed(0, 31);
      repeat (6) tick();
      check("bp valid", 32'(spk_valid), 32'd1);
      check("bp overflow", 32'(evt_overflow), 32'd1);
      check("bp head", spk_data, ev(37, 1'b0, 10));
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("bp stall data %0d", k), spk_data, ev(37, 1'b0, 10));
         check($sformatf("bp stall valid %0d", k), 32'(spk_valid), 32'd1);
      end
      spk_ready = 1'b1;
      repeat (20) tick();
      for (int c = 10; c <= 25; c++) req_q.push_back(ev(37, 1'b0, c));
      cmp_events("drain");
      check("drain empty", 32'(spk_valid), 32'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("overflow cleared", 32'(evt_overflow), 32'd0);

      // Frame 38: reset while an event is pending and mid-frame
      set_all(16'h8000);
      smp[27]   = 16'h7000;
      spk_ready = 1'b0;
      feed(0, 27);
      repeat (4) tick();
      check("pre-reset valid", 32'(spk_valid), 32'd1);
      reset_n = 1'b0;
      #2;
      check("async reset valid", 32'(spk_valid), 32'd0);
      check("async reset data", spk_data, 32'd0);
      reset_n = 1'b1;
      tick();
      spk_ready = 1'b1;
      // Index and ts restart at 0 without sof: second sample lands on ch1, ts 0
      data = 16'h8000;
      wen  = 1'b1;
      tick();
      data = 16'h7000;
      tick();
      wen = 1'b0;
      repeat (6) tick();
      req_q.push_back(ev(0, 1'b0, 1));
      cmp_events("post reset");
      check("post reset frame_err", 32'(frame_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xike_spike_detector.md
Name: xike_spike_detector

Overview:
- Consumes the 16-bit per-channel amplifier sample stream that the SPI acquisition stage emits for on-FPGA spike processing (FIFO_DATA_TO_XIKE / _WEN).
- Runs per-channel threshold-crossing detection with refractory lockout and timestamps each detected spike with a frame counter.
- Buffers the resulting spike events in a small FIFO behind a valid/ready interface for the downstream event packer.

Parameters:
- NUM_CH, 32, channels per frame; valid range 1..256.
- REFRACT, 30, refractory length in frames after a spike; valid range 1..255.
- THR_DEFAULT, 16'h0200, per-channel threshold magnitude loaded at reset.
- EVT_DEPTH, 16, event FIFO depth; must be a power of 2, ≥2.

Ports:
- spi_clk  in  1  single clock for all logic.
- reset_n  in  1  reset, asynchronous, active-low.
- FIFO_DATA_TO_XIKE  in  16  sample, offset binary (16'h8000 = 0 V).
- FIFO_DATA_TO_XIKE_WEN  in  1  sample strobe; one sample per high cycle.
- sof  in  1  asserted together with WEN on channel 0 of each frame.
- detect_en  in  1  detection enable.
- thr_we  in  1  threshold write strobe.
- thr_addr  in  8  threshold channel index.
- thr_data  in  16  threshold magnitude, unsigned.
- ovf_clr  in  1  clears the sticky overflow flags.
- spk_valid  out  1  event available.
- spk_ready  in  1  consumer accepts event.
- spk_data  out  32  {ts[22:0], pol, ch[7:0]}.
- evt_overflow  out  1  sticky: an event was dropped.
- frame_err  out  1  sticky: sof arrived with the channel index ≠ 0.

Behaviour:
- Reset values:
  - All outputs 0.
  - Channel index 0, timestamp 0.
  - All thresholds = THR_DEFAULT.
  - All refractory counters 0.
  - All prev_below bits 0.
  - Event FIFO empty.
- Channel index:
  - Advances on each WEN; wraps from NUM_CH-1 to 0.
  - On wrap, ts increments and wraps modulo 2^23.
  - WEN with sof forces the index to 0 for that sample. If the index was ≠0, frame_err is set and ts is NOT incremented.
- Signed conversion: s = {~d[15], d[14:0]}. Threshold comparison is 17-bit signed: below = (s < -thr). With thr = 0, below = (s < 0).
- Pipeline:
  - Stage 1 registers the sample and channel index.
  - Stage 2 reads the channel state, evaluates, writes the state back, and pushes the event.
  - An event is visible on spk_valid 3 cycles after the accepted WEN edge.
  - Back-to-back WEN is supported. The same channel recurs only after NUM_CH samples, so there is no read/write hazard for NUM_CH ≥ 2. For NUM_CH = 1, stage 2 forwards its own write-back.
- Detection, per sample:
  - spike = detect_en & below & ~prev_below[ch] & (refr[ch] == 0).
  - On a spike, refr[ch] = REFRACT.
  - Otherwise, if refr[ch] ≠ 0, refr[ch] decrements by 1.
  - prev_below[ch] = below, updated regardless of detect_en.
  - When detect_en = 0, refr[ch] is cleared on each visit.
- Threshold writes:
  - Take effect on the next sample for that channel.
  - thr_addr ≥ NUM_CH is ignored.
  - A write in the same cycle as stage 2 reads that channel: the old value is used.
- Event FIFO:
  - Pop when spk_valid & spk_ready.
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - A push while full without a pop drops the event and sets evt_overflow.
  - spk_data holds stable while spk_valid = 1 and spk_ready = 0.
- ovf_clr clears evt_overflow and frame_err. If ovf_clr coincides with a new overflow, the flag stays set.
- reset_n assertion mid-frame or mid-handshake returns everything to the reset state immediately.

Optional Feature:
- XIKE_DUAL_POLARITY_EN defined:
  - A second per-channel bit prev_above is added, with above = (s > thr).
  - A positive crossing (above & ~prev_above) also triggers a spike with pol = 1; negative crossings use pol = 0.
  - Both polarities share refr[ch]. Negative wins if both crossings occur on the same sample, which is impossible for thr > 0.
- Undefined: only negative crossings are detected, pol is always 0, and no prev_above storage exists.

Decomposition:
- Package xike_pkg holds:
  - TS_W = 23, CH_W = 8.
  - The event field offsets.
  - The function to_signed(d).
- Sub-module xike_evt_fifo holds the synchronous FIFO, parameterized by width and depth, with full/empty and the pop-while-full rule.
- The detector core stays in the top module.

Test Plan:
- Channel 3, threshold 0x0200:
  - Stimulus: samples 0x8000, 0x7D00, 0x7D00, then 0x8000 repeated.
  - Expect exactly one event {ts = 1, pol = 0, ch = 3} 3 cycles after the second sample.
  - Expect no event for the following REFRACT = 30 frames.
- Refractory: channel 0 sample sequence 0x7000, 0x8000, 0x7000 on consecutive frames.
  - Expect the second crossing suppressed.
  - Repeating at frame 32 (after refractory expires) yields a new event.
- Backpressure:
  - Stimulus: hold spk_ready = 0 and generate 17 spikes.
  - Expect 16 events stored and evt_overflow = 1.
  - Then ready = 1: expect 16 events drained in order, with data stable while stalled.
- Frame sync: assert sof at channel index 5.
  - Expect frame_err = 1, index reset to 0, ts unchanged.
  - ovf_clr then clears frame_err.
- Threshold write: write thr = 0 to channel 2 mid-frame, then feed sample 0x7FFF.
  - Expect a spike on channel 2.
  - Write to thr_addr = 40 and verify there is no effect.
- With XIKE_DUAL_POLARITY_EN: channel 1 sample 0x8300 with thr 0x0200.
  - Expect event pol = 1.
  - Without the macro: no event.
